// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, opcodes and IR field positions for the phase-1 datapath
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [2*XLEN-1:0] dword_t;
  typedef logic [4:0]        opcode_t;

  // IR field positions; only the opcode is decoded in this phase
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_SHR  = 5'b00101;
  localparam opcode_t OP_SHRA = 5'b00110;
  localparam opcode_t OP_SHL  = 5'b00111;
  localparam opcode_t OP_ROR  = 5'b01000;
  localparam opcode_t OP_ROL  = 5'b01001;
  localparam opcode_t OP_AND  = 5'b01010;
  localparam opcode_t OP_OR   = 5'b01011;
  localparam opcode_t OP_DIV  = 5'b01111;
  localparam opcode_t OP_MUL  = 5'b10000;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;

  function automatic opcode_t ir_opcode(input word_t ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational 64-bit-result ALU decoded from the IR opcode
module cpu_alu
  import cpu_pkg::*;
(
  input  opcode_t opcode,
  input  word_t   a,
  input  word_t   b,
  output dword_t  result
);

  logic [4:0]         sh;
  logic [63:0]        dbl;
  logic signed [31:0] shra;
  logic signed [31:0] quot;
  logic signed [31:0] rem;
  logic signed [63:0] prod;

  assign sh = b[4:0];

  // opcode decode; 32-bit results leave the high word at zero
  always_comb begin
    result = '0;
    dbl    = '0;
    shra   = '0;
    quot   = '0;
    rem    = '0;
    prod   = '0;
    case (opcode)
      OP_ADD:  result = {32'h0, a + b};
      OP_SUB:  result = {32'h0, a - b};
      OP_SHR:  result = {32'h0, a >> sh};
      OP_SHRA: begin
        shra   = $signed(a) >>> sh;
        result = {32'h0, shra};
      end
      OP_SHL:  result = {32'h0, a << sh};
      OP_ROR: begin
        // doubling the word turns a rotate into a plain shift
        dbl    = {a, a} >> sh;
        result = {32'h0, dbl[31:0]};
      end
      OP_ROL: begin
        dbl    = {a, a} << sh;
        result = {32'h0, dbl[63:32]};
      end
      OP_AND:  result = {32'h0, a & b};
      OP_OR:   result = {32'h0, a | b};
      OP_DIV: begin
        if (b == 32'h0) begin
          result = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // the one overflowing quotient wraps back to the dividend
          result = {32'h0, a};
        end else begin
          quot   = $signed(a) / $signed(b);
          rem    = $signed(a) % $signed(b);
          result = {rem, quot};
        end
      end
      OP_MUL: begin
        prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        result = prod;
      end
      OP_NEG:  result = {32'h0, 32'h0 - b};
      OP_NOT:  result = {32'h0, ~b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_reg.sv
// rtl/cpu_reg.sv - generic load-enable register with synchronous clear
module cpu_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // hold unless the load strobe is high
  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  // clear wins over any load
  always_ff @(posedge clk) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/cpu.sv
// rtl/cpu.sv - phase-1 datapath: register file, shared bus, ALU and Z
module cpu
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        IncPC,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        R0in,   input logic R1in,   input logic R2in,   input logic R3in,
  input  logic        R4in,   input logic R5in,   input logic R6in,   input logic R7in,
  input  logic        R8in,   input logic R9in,   input logic R10in,  input logic R11in,
  input  logic        R12in,  input logic R13in,  input logic R14in,  input logic R15in,
  input  logic        MARin,
  input  logic        MDRout,
  input  logic        MDRin,
  input  logic        memRead,
  input  logic [31:0] mDataIn,
  output logic [31:0] mDataOut,
  input  logic        PCout,
  input  logic        Zin,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Yin,
  input  logic        IRin
);

  logic [NREGS-1:0] r_out;
  logic [NREGS-1:0] r_in;
  word_t            r_q [NREGS];
  word_t            bus;
  word_t            pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
  word_t            mdr_src;
  dword_t           z_q;
  dword_t           alu_result;
  logic             unused_mar_ir;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // bus encoder: later assignments win, so the lowest-priority source goes first
  always_comb begin
    bus = '0;
    if (MDRout)   bus = mdr_q;
    if (PCout)    bus = pc_q;
    if (Zlowout)  bus = z_q[31:0];
    if (Zhighout) bus = z_q[63:32];
    if (LOout)    bus = lo_q;
    if (HIout)    bus = hi_q;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    cpu_reg #(.WIDTH(32)) u_r (
      .clk(clock), .clear(clear), .en(r_in[g]), .d(bus), .q(r_q[g])
    );
  end

  assign mdr_src = memRead ? mDataIn : bus;

  cpu_reg #(.WIDTH(32)) u_pc  (.clk(clock), .clear(clear), .en(IncPC), .d(pc_q + 32'd1), .q(pc_q));
  cpu_reg #(.WIDTH(32)) u_ir  (.clk(clock), .clear(clear), .en(IRin),  .d(bus),          .q(ir_q));
  cpu_reg #(.WIDTH(32)) u_mar (.clk(clock), .clear(clear), .en(MARin), .d(bus),          .q(mar_q));
  cpu_reg #(.WIDTH(32)) u_mdr (.clk(clock), .clear(clear), .en(MDRin), .d(mdr_src),      .q(mdr_q));
  cpu_reg #(.WIDTH(32)) u_y   (.clk(clock), .clear(clear), .en(Yin),   .d(bus),          .q(y_q));
  cpu_reg #(.WIDTH(32)) u_hi  (.clk(clock), .clear(clear), .en(HIin),  .d(bus),          .q(hi_q));
  cpu_reg #(.WIDTH(32)) u_lo  (.clk(clock), .clear(clear), .en(LOin),  .d(bus),          .q(lo_q));
  cpu_reg #(.WIDTH(64)) u_z   (.clk(clock), .clear(clear), .en(Zin),   .d(alu_result),   .q(z_q));

  cpu_alu u_alu (
    .opcode(ir_opcode(ir_q)),
    .a     (y_q),
    .b     (bus),
    .result(alu_result)
  );

  assign mDataOut = mdr_q;

  // MAR and the IR register fields have no consumer until the memory/control phase
  assign unused_mar_ir = ^{mar_q, ir_q[OPC_LSB-1:0]};

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard bench for the phase-1 datapath
module tb_cpu;

  localparam logic [4:0] B_ADD = 5'b00011, B_SUB = 5'b00100, B_SHR = 5'b00101;
  localparam logic [4:0] B_SHRA = 5'b00110, B_SHL = 5'b00111, B_ROR = 5'b01000;
  localparam logic [4:0] B_ROL = 5'b01001, B_AND = 5'b01010, B_OR = 5'b01011;
  localparam logic [4:0] B_DIV = 5'b01111, B_MUL = 5'b10000, B_NEG = 5'b10001;
  localparam logic [4:0] B_NOT = 5'b10010, B_BAD = 5'b11111;

  localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_MDR = 21, S_NONE = 22;

  logic        clock = 1'b0;
  logic        clear, IncPC, MARin, MDRout, MDRin, memRead, PCout, Zin;
  logic        Zhighout, Zlowout, HIin, LOin, HIout, LOout, Yin, IRin;
  logic [15:0] r_out, r_in;
  logic [31:0] mDataIn, mDataOut;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  cpu dut (
    .clock(clock), .clear(clear), .IncPC(IncPC),
    .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
    .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
    .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .R0in(r_in[0]),     .R1in(r_in[1]),     .R2in(r_in[2]),     .R3in(r_in[3]),
    .R4in(r_in[4]),     .R5in(r_in[5]),     .R6in(r_in[6]),     .R7in(r_in[7]),
    .R8in(r_in[8]),     .R9in(r_in[9]),     .R10in(r_in[10]),   .R11in(r_in[11]),
    .R12in(r_in[12]),   .R13in(r_in[13]),   .R14in(r_in[14]),   .R15in(r_in[15]),
    .MARin(MARin), .MDRout(MDRout), .MDRin(MDRin), .memRead(memRead),
    .mDataIn(mDataIn), .mDataOut(mDataOut), .PCout(PCout), .Zin(Zin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
    .HIout(HIout), .LOout(LOout), .Yin(Yin), .IRin(IRin)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clear = 0; IncPC = 0; MARin = 0; MDRout = 0; MDRin = 0; memRead = 0; PCout = 0;
    Zin = 0; Zhighout = 0; Zlowout = 0; HIin = 0; LOin = 0; HIout = 0; LOout = 0;
    Yin = 0; IRin = 0; r_out = '0; r_in = '0; mDataIn = '0;
  endtask

  // one edge; strobes are driven and outputs sampled at the falling edge
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic set_src(input int src);
    if (src < 16) r_out[src] = 1'b1;
    else case (src)
      S_HI:    HIout = 1;
      S_LO:    LOout = 1;
      S_ZH:    Zhighout = 1;
      S_ZL:    Zlowout = 1;
      S_PC:    PCout = 1;
      S_MDR:   MDRout = 1;
      default: ;
    endcase
  endtask

  // route a source over the bus into MDR, then compare against the next expectation
  task automatic observe(input int src);
    string       tag;
    logic [31:0] exp;
    set_src(src);
    MDRin = 1;
    tick();
    idle();
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard underflow at source %0d", src);
      $fatal(1);
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    check(tag, mDataOut, exp);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    memRead = 1; mDataIn = v; MDRin = 1;
    tick();
    idle();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; r_in[idx] = 1;
    tick();
    idle();
  endtask

  task automatic load_ir(input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; IRin = 1;
    tick();
    idle();
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string name);
    push_exp({name, "_lo"}, exp[31:0]);
    push_exp({name, "_hi"}, exp[63:32]);
    load_ir({op, 27'h0});
    load_reg(4, a);
    load_reg(5, b);
    r_out[4] = 1; Yin = 1;
    tick();
    idle();
    r_out[5] = 1; Zin = 1;
    tick();
    idle();
    observe(S_ZL);
    observe(S_ZH);
  endtask

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [31:0] t;
    t = 32'h0;
    case (op)
      B_ADD: t = a + b;
      B_SUB: t = a + ~b + 32'd1;
      B_AND: t = a & b;
      B_OR:  t = a | b;
      B_NEG: t = ~b + 32'd1;
      B_NOT: t = b ^ 32'hFFFF_FFFF;
      B_MUL: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        return 64'(p);
      end
      default: t = 32'h0;
    endcase
    return {32'h0, t};
  endfunction

  initial begin
    logic [4:0]  rops [7];
    logic [31:0] ra, rb;

    idle();
    clear = 1;
    tick();
    idle();

    // reset state
    check("reset_mdata", mDataOut, 32'h0);
    for (int i = 0; i < 16; i++) begin
      push_exp($sformatf("reset_r%0d", i), 32'h0);
      observe(i);
    end
    push_exp("reset_hi", 32'h0); observe(S_HI);
    push_exp("reset_lo", 32'h0); observe(S_LO);
    push_exp("reset_zh", 32'h0); observe(S_ZH);
    push_exp("reset_zl", 32'h0); observe(S_ZL);
    push_exp("reset_pc", 32'h0); observe(S_PC);

    // idle bus reads as zero
    load_mdr(32'hAAAA_5555);
    push_exp("bus_idle", 32'h0);
    observe(S_NONE);

    // SHR through the three-step register transfer
    load_reg(2, 32'hFFFF_FF0A);
    load_reg(3, 32'd7);
    load_ir(32'h2891_8000);
    r_out[2] = 1; Yin = 1; tick(); idle();
    r_out[3] = 1; Zin = 1; tick(); idle();
    Zlowout = 1; r_in[1] = 1; tick(); idle();
    push_exp("shr_r1", 32'h01FF_FFFE);
    observe(1);

    // fetch T0: old PC on the bus, PC increments
    PCout = 1; MARin = 1; IncPC = 1; MDRin = 1;
    tick(); idle();
    check("t0_bus_old_pc", mDataOut, 32'h0);
    push_exp("t0_pc", 32'd1);
    observe(S_PC);
    // T1/T2
    memRead = 1; mDataIn = 32'h1234_5678; MDRin = 1; tick(); idle();
    check("t1_mdata", mDataOut, 32'h1234_5678);
    MDRout = 1; IRin = 1; tick(); idle();
    // opcode 00010 is unmapped, so Z must drop to zero
    Zin = 1; tick(); idle();
    push_exp("t2_unmapped_zl", 32'h0);
    observe(S_ZL);

    // directed ALU results
    alu_run(B_ADD,  32'd5,         32'd7,         64'h0000_0000_0000_000C, "add");
    alu_run(B_SUB,  32'd5,         32'd7,         64'h0000_0000_FFFF_FFFE, "sub");
    alu_run(B_DIV,  32'd17,        32'd5,         64'h0000_0002_0000_0003, "div");
    alu_run(B_DIV,  32'hFFFF_FFEF, 32'd5,         64'hFFFF_FFFE_FFFF_FFFD, "div_neg");
    alu_run(B_DIV,  32'd9,         32'd0,         64'h0000_0009_FFFF_FFFF, "div_zero");
    alu_run(B_SHRA, 32'h8000_0000, 32'd31,        64'h0000_0000_FFFF_FFFF, "shra31");
    alu_run(B_SHRA, 32'h4000_0000, 32'd30,        64'h0000_0000_0000_0001, "shra_pos");
    alu_run(B_ROL,  32'h8000_0001, 32'd1,         64'h0000_0000_0000_0003, "rol1");
    alu_run(B_ROR,  32'h0000_0001, 32'd1,         64'h0000_0000_8000_0000, "ror1");
    alu_run(B_ROR,  32'h1234_5678, 32'd36,        64'h0000_0000_8123_4567, "ror36");
    alu_run(B_SHR,  32'h0000_1234, 32'd32,        64'h0000_0000_0000_1234, "shr32");
    alu_run(B_SHL,  32'h0000_1234, 32'd32,        64'h0000_0000_0000_1234, "shl32");
    alu_run(B_SHL,  32'h0000_0001, 32'd31,        64'h0000_0000_8000_0000, "shl31");
    alu_run(B_NEG,  32'd0,         32'd5,         64'h0000_0000_FFFF_FFFB, "neg");
    alu_run(B_BAD,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   "bad_op");

    // MUL into HI/LO
    alu_run(B_MUL, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mul");
    Zhighout = 1; HIin = 1; tick(); idle();
    Zlowout = 1; LOin = 1; tick(); idle();
    push_exp("mul_hi", 32'hFFFF_FFFF); observe(S_HI);
    push_exp("mul_lo", 32'hFFFF_FFFE); observe(S_LO);

    // random operands against the bench model
    rops = '{B_ADD, B_SUB, B_AND, B_OR, B_MUL, B_NEG, B_NOT};
    for (int i = 0; i < 7; i++) begin
      ra = $urandom;
      rb = $urandom;
      alu_run(rops[i], ra, rb, model(rops[i], ra, rb), $sformatf("rand%0d", i));
    end

    // clear mid-sequence with competing strobes
    load_reg(2, 32'd10);
    load_reg(7, 32'hDEAD_BEEF);
    load_ir({B_ADD, 27'h0});
    r_out[2] = 1; Yin = 1; tick(); idle();
    IncPC = 1; IncPC = 1; tick(); idle();
    clear = 1; IncPC = 1; MDRout = 1; r_in[7] = 1; Zin = 1; HIin = 1;
    tick(); idle();
    check("clear_mdata", mDataOut, 32'h0);
    push_exp("clear_pc", 32'h0);  observe(S_PC);
    push_exp("clear_r7", 32'h0);  observe(7);
    push_exp("clear_hi", 32'h0);  observe(S_HI);
    // Y must be zero: Z = Y + 20
    load_reg(3, 32'd20);
    load_ir({B_ADD, 27'h0});
    r_out[3] = 1; Zin = 1; tick(); idle();
    push_exp("clear_y", 32'd20);
    observe(S_ZL);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
